// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive side of one TMDS lane.
// Finds the 10-bit word boundary by locking onto blanking-interval control
// token runs, then decodes each aligned word to a pixel byte or control value.
// Optional build macro: TMDS_DEC_STATS_EN enables the 16-bit lock-loss counter
// on lock_loss_o; without it the port is tied to zero.
module tmds_channel_decoder #(
  parameter int C_TOKEN_RUN = 8,
  parameter int C_LOCK_RUNS = 4,
  parameter int C_WINDOW    = 4096
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic [9:0]  raw_i,
  output logic [7:0]  data_o,
  output logic [1:0]  c_o,
  output logic        de_o,
  output logic        locked_o,
  output logic [3:0]  offset_o,
  output logic [15:0] lock_loss_o
);

  localparam int W_WIN = $clog2(C_WINDOW);
  localparam int W_TOK = $clog2(C_TOKEN_RUN + 1);
  localparam int W_RUN = $clog2(C_LOCK_RUNS + 1);
  localparam logic [W_WIN-1:0] C_WIN_LAST  = W_WIN'(C_WINDOW - 1);
  localparam logic [W_TOK-1:0] C_TOK_LAST  = W_TOK'(C_TOKEN_RUN - 1);
  localparam logic [W_TOK-1:0] C_TOK_FULL  = W_TOK'(C_TOKEN_RUN);
  localparam logic [W_RUN-1:0] C_RUNS_LOCK = W_RUN'(C_LOCK_RUNS);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t             r_state, w_state_next;
  logic [9:0]         r_raw_q1, r_raw_q2, r_aligned;
  logic [3:0]         r_offset, w_offset_next;
  logic [W_TOK-1:0]   r_tok_run, w_tok_run_next;
  logic [W_WIN-1:0]   r_win_cnt, w_win_cnt_next;
  logic [W_RUN-1:0]   r_runs, w_runs_next, w_runs_inc;
  logic [7:0]         r_data;
  logic [1:0]         r_c;
  logic               r_de;

  logic [19:0]        w_cat;
  logic [9:0]         w_cand [10];
  logic [9:0]         w_aligned;
  logic               w_is_tok;
  logic [1:0]         w_tok_c;
  logic [7:0]         w_b, w_dec;
  logic               w_run_evt, w_expire, w_off_chg;

  // Stage 1: current and previous raw words (previous word holds the earlier bits)
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_q1 <= '0;
      r_raw_q2 <= '0;
    end else begin
      r_raw_q1 <= raw_i;
      r_raw_q2 <= r_raw_q1;
    end
  end

  assign w_cat = {r_raw_q1, r_raw_q2};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cand
      assign w_cand[gi] = w_cat[gi+9:gi];
    end
  endgenerate

  // Bit-slip mux: pick the 10-bit window starting at the current offset
  always_comb begin
    w_aligned = w_cand[0];
    for (int i = 1; i < 10; i++) begin
      if (r_offset == 4'(i)) w_aligned = w_cand[i];
    end
  end

  // Stage 2: aligned word register
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) r_aligned <= '0;
    else        r_aligned <= w_aligned;
  end

  // Control token recognition on the stage-2 word
  always_comb begin
    w_is_tok = 1'b1;
    w_tok_c  = 2'b00;
    case (r_aligned)
      10'h354: w_tok_c = 2'b00;
      10'h0AB: w_tok_c = 2'b01;
      10'h154: w_tok_c = 2'b10;
      10'h2AB: w_tok_c = 2'b11;
      default: w_is_tok = 1'b0;
    endcase
  end

  // Data decode: undo optional inversion, then undo XOR/XNOR chaining
  assign w_b      = r_aligned[9] ? ~r_aligned[7:0] : r_aligned[7:0];
  assign w_dec[0] = w_b[0];
  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign w_dec[gi] = r_aligned[8] ? (w_b[gi] ^ w_b[gi-1]) : ~(w_b[gi] ^ w_b[gi-1]);
    end
  endgenerate

  // Stage 3: decoded outputs; c holds the last token value across data
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_c    <= '0;
      r_de   <= 1'b0;
    end else begin
      r_data <= w_dec;
      r_de   <= ~w_is_tok;
      if (w_is_tok) r_c <= w_tok_c;
    end
  end

  assign w_run_evt  = w_is_tok && (r_tok_run == C_TOK_LAST);
  assign w_expire   = (r_win_cnt == C_WIN_LAST);
  assign w_runs_inc = r_runs + 1'b1;

  // Alignment FSM next state; a run event always takes priority over expiry
  always_comb begin
    w_state_next = r_state;
    w_runs_next  = r_runs;
    w_off_chg    = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_run_evt) begin
          w_state_next = ST_VERIFY;
          w_runs_next  = W_RUN'(1);
        end else if (w_expire) begin
          w_off_chg = 1'b1;
        end
      end
      ST_VERIFY: begin
        if (w_run_evt) begin
          w_runs_next = w_runs_inc;
          if (w_runs_inc >= C_RUNS_LOCK) w_state_next = ST_LOCKED;
        end else if (w_expire) begin
          w_state_next = ST_SEARCH;
          w_runs_next  = '0;
          w_off_chg    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!w_run_evt && w_expire) begin
          w_state_next = ST_SEARCH;
          w_runs_next  = '0;
          w_off_chg    = 1'b1;
        end
      end
      default: w_state_next = ST_SEARCH;
    endcase

    w_offset_next = r_offset;
    if (w_off_chg) w_offset_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    if (w_off_chg)     w_tok_run_next = '0;
    else if (w_is_tok) w_tok_run_next = (r_tok_run == C_TOK_FULL) ? r_tok_run : r_tok_run + 1'b1;
    else               w_tok_run_next = '0;

    if (w_run_evt || w_off_chg) w_win_cnt_next = '0;
    else                        w_win_cnt_next = r_win_cnt + 1'b1;
  end

  // Alignment FSM state and counters
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SEARCH;
      r_offset  <= '0;
      r_tok_run <= '0;
      r_win_cnt <= '0;
      r_runs    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_offset  <= w_offset_next;
      r_tok_run <= w_tok_run_next;
      r_win_cnt <= w_win_cnt_next;
      r_runs    <= w_runs_next;
    end
  end

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] r_lock_loss;

  // Count LOCKED->SEARCH transitions, saturating
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss <= '0;
    end else if (r_state == ST_LOCKED && w_state_next == ST_SEARCH && r_lock_loss != 16'hFFFF) begin
      r_lock_loss <= r_lock_loss + 16'd1;
    end
  end

  assign lock_loss_o = r_lock_loss;
`else
  assign lock_loss_o = '0;
`endif

  assign data_o   = r_data;
  assign c_o      = r_c;
  assign de_o     = r_de;
  assign locked_o = (r_state == ST_LOCKED);
  assign offset_o = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: symbols are produced by an
// independent TMDS encoder, serialised with a chosen bit rotation, and the
// expected decode for each symbol is queued and compared three stages later.
module tb_tmds_channel_decoder;

  localparam int WIN = 2048;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  raw_i = '0;
  logic [7:0]  data_o;
  logic [1:0]  c_o;
  logic        de_o;
  logic        locked_o;
  logic [3:0]  offset_o;
  logic [15:0] lock_loss_o;

  tmds_channel_decoder #(.C_TOKEN_RUN(8), .C_LOCK_RUNS(4), .C_WINDOW(WIN)) dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .raw_i       (raw_i),
    .data_o      (data_o),
    .c_o         (c_o),
    .de_o        (de_o),
    .locked_o    (locked_o),
    .offset_o    (offset_o),
    .lock_loss_o (lock_loss_o)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
    bit         chk;
    bit         lkchk;
    bit         lk;
  } exp_t;

  exp_t        sb[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_chg = 0;
  int          enc_disp = 0;
  int          rot = 0;
  int          line_no = 0;
  logic [3:0]  prev_off = '0;
  logic [1:0]  last_c = '0;
  logic [9:0]  prev_sym = '0;
  bit          have_last = 0;
  bit          iv_en = 0;
  bit          wrap_seen = 0;
  bit          lk_seen = 0;
  bit          drop_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // DVI-style 8b/10b encoder with running disparity
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1, n0;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (enc_disp == 0 || n1 == n0) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) enc_disp += n1 - n0;
      else       enc_disp += n0 - n1;
    end else if ((enc_disp > 0 && n1 > n0) || (enc_disp < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_disp += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_disp += -(qm[8] ? 0 : 2) + n1 - n0;
    end
    return q;
  endfunction

  function automatic logic [1:0] tok_c(input logic [9:0] w);
    case (w)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // One clock: serialise symbol with rotation, queue expectation, compare the due entry
  task automatic drive(input logic [9:0] sym, input exp_t e);
    logic [19:0] cat;
    exp_t f;
    cat = {sym, prev_sym};
    raw_i = cat[(10 - rot) +: 10];
    prev_sym = sym;
    sb.push_back(e);
    @(posedge clk_pixel);
    #1;
    cyc++;
    lk_seen = lk_seen | locked_o;
    if (offset_o != prev_off) begin
      check_eq("offset_step", 32'(offset_o), 32'((prev_off == 4'd9) ? 4'd0 : prev_off + 4'd1));
      if (prev_off == 4'd9) wrap_seen = 1;
      if (iv_en && have_last) check_eq("step_interval", 32'(cyc - last_chg), 32'(WIN));
      have_last = 1;
      last_chg = cyc;
      prev_off = offset_o;
    end
    if (sb.size() >= 4) begin
      f = sb.pop_front();
      if (f.chk) begin
        check_eq("de", 32'(de_o), 32'(f.de));
        check_eq("c", 32'(c_o), 32'(f.c));
        if (f.de) check_eq("data", 32'(data_o), 32'(f.d));
      end
      if (f.lkchk) check_eq("lock_edge", 32'(locked_o), 32'(f.lk));
    end
  endtask

  task automatic tok_word(input logic [9:0] w, input bit chk, input bit lkchk, input bit lk);
    exp_t e;
    e.de = 1'b0; e.c = tok_c(w); e.d = '0; e.chk = chk; e.lkchk = lkchk; e.lk = lk;
    last_c = e.c;
    drive(w, e);
  endtask

  task automatic data_byte(input logic [7:0] b, input bit chk);
    exp_t e;
    e.de = 1'b1; e.c = last_c; e.d = b; e.chk = chk; e.lkchk = 0; e.lk = 0;
    drive(tmds_enc(b), e);
  endtask

  task automatic raw_data(input logic [9:0] w, input logic [7:0] d);
    exp_t e;
    e.de = 1'b1; e.c = last_c; e.d = d; e.chk = 1; e.lkchk = 0; e.lk = 0;
    drive(w, e);
  endtask

  // lock_line: this is the line whose run event must complete lock
  task automatic send_line(input int n_tok, input logic [9:0] tok, input int n_data,
                           input bit chk, input bit lock_line);
    for (int i = 0; i < n_tok; i++)
      tok_word(tok, chk, lock_line && (i == 6 || i == 7), i == 7);
    for (int j = 0; j < n_data; j++)
      data_byte(8'($urandom_range(0, 255)), chk);
    line_no++;
    $display("line %0d: %0d x %03h + %0d data, rot %0d, offset %0d, locked %0b",
             line_no, n_tok, tok, n_data, rot, offset_o, locked_o);
  endtask

  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    raw_i = '0;
    sb.delete();
    if (chk) begin
      #1;
      check_eq("rst_data", 32'(data_o), 32'd0);
      check_eq("rst_c", 32'(c_o), 32'd0);
      check_eq("rst_de", 32'(de_o), 32'd0);
      check_eq("rst_locked", 32'(locked_o), 32'd0);
      check_eq("rst_offset", 32'(offset_o), 32'd0);
      check_eq("rst_lock_loss", 32'(lock_loss_o), 32'd0);
    end
    repeat (3) @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    prev_off = '0; prev_sym = '0; last_c = '0; enc_disp = 0;
    have_last = 0; wrap_seen = 0; lk_seen = 0; drop_seen = 0;
    $display("reset released at cycle %0d", cyc);
  endtask

  initial begin
    #3;
    do_reset(1);

    // Directed tokens and raw data words, offset 0 straight after reset
    rot = 0;
    repeat (3) tok_word(10'h0AB, 1, 0, 0);
    repeat (2) raw_data(10'h1FF, 8'h01);   // b=0xFF: d0=1, XOR of equal neighbours = 0
    repeat (3) tok_word(10'h154, 1, 0, 0);
    repeat (2) raw_data(10'h100, 8'h00);
    repeat (3) tok_word(10'h2AB, 1, 0, 0);
    raw_data(10'h1FF, 8'h01);
    repeat (3) tok_word(10'h354, 1, 0, 0);
    $display("directed token/data words sent");

    // Aligned stream: lock on the 4th line, then check decode
    for (int l = 1; l <= 4; l++) send_line(100, 10'h354, 700, 0, l == 4);
    check_eq("aligned_locked", 32'(locked_o), 32'd1);
    check_eq("aligned_offset", 32'(offset_o), 32'd0);
    for (int l = 0; l < 2; l++) send_line(100, 10'h354, 700, 1, 0);

    // Reset mid-line while locked
    send_line(100, 10'h354, 300, 0, 0);
    check_eq("pre_rst_locked", 32'(locked_o), 32'd1);
    do_reset(1);
    for (int l = 1; l <= 4; l++) send_line(100, 10'h354, 700, 0, l == 4);
    check_eq("relock_locked", 32'(locked_o), 32'd1);
    check_eq("relock_offset", 32'(offset_o), 32'd0);
    send_line(100, 10'h354, 700, 1, 0);

    // Stream rotated by 7 bits: offset must walk up to 7 and lock there
    do_reset(0);
    rot = 7;
    for (int l = 0; l < 24; l++) send_line(100, 10'h354, 700, 0, 0);
    check_eq("rot_locked", 32'(locked_o), 32'd1);
    check_eq("rot_offset", 32'(offset_o), 32'd7);
    for (int l = 0; l < 2; l++) send_line(100, 10'h354, 700, 1, 0);

    // Tokens stop while locked: lock drops at window expiry, offset moves on
    for (int i = 0; i < 5000; i++) begin
      data_byte(8'($urandom_range(0, 255)), 0);
      if (!drop_seen && !locked_o) begin
        drop_seen = 1;
        check_eq("drop_offset", 32'(offset_o), 32'd8);
      end
    end
    $display("5000 data words without tokens sent, offset %0d", offset_o);
    check_eq("drop_seen", 32'(drop_seen), 32'd1);
`ifdef TMDS_DEC_STATS_EN
    check_eq("lock_loss", 32'(lock_loss_o), 32'd1);
`else
    check_eq("lock_loss", 32'(lock_loss_o), 32'd0);
`endif

    // Token runs one short of a run: never leaves SEARCH, offset wraps
    do_reset(0);
    rot = 0;
    iv_en = 1;
    for (int l = 0; l < 369; l++) send_line(7, 10'h354, 50, 0, 0);
    iv_en = 0;
    check_eq("short_run_never_locked", 32'(lk_seen), 32'd0);
    check_eq("offset_wrapped", 32'(wrap_seen), 32'd1);
    check_eq("short_run_offset", 32'(offset_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
